idma_reg_queue_frontend: RTL and testbench

//  Register-mapped iDMA frontend. Software programs a transfer, then reads NEXT_ID to enqueue it into a

---
 rtl/idma_reg_queue_pkg.sv | 51 +++++
 rtl/idma_desc_queue.sv | 41 ++++
 rtl/idma_reg_queue_frontend.sv | 124 ++++++++++++
 tb/tb_idma_reg_queue_frontend.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_reg_queue_pkg.sv
// idma_reg_queue_pkg: register map, field positions and default burst request type
package idma_reg_queue_pkg;
  localparam logic [2:0] REG_SRC_ADDR = 3'd0;
  localparam logic [2:0] REG_DST_ADDR = 3'd1;
  localparam logic [2:0] REG_NUM_BYTES = 3'd2;
  localparam logic [2:0] REG_CONF = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_NEXT_ID = 3'd5;
  localparam logic [2:0] REG_DONE_ID = 3'd6;
  localparam logic [2:0] REG_IRQ = 3'd7;
  localparam int unsigned CONF_DECOUPLE = 0;
  localparam int unsigned CONF_DEBURST = 1;
  localparam int unsigned CONF_IRQ_EN = 2;
  localparam int unsigned CONF_W = 3;
  localparam int unsigned STATUS_BUSY = 0;
  localparam int unsigned STATUS_FULL = 1;
  localparam int unsigned STATUS_LEVEL = 2;
  localparam int unsigned IRQ_PENDING = 0;
  localparam logic [1:0] BURST_INCR = 2'b01;
  typedef struct packed {
    logic [1:0] burst;
    logic [3:0] cache;
    logic       lock;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } axi_opt_t;
  typedef struct packed {
    logic       decouple_aw;
    logic       decouple_rw;
    logic [2:0] src_max_llen;
    logic [2:0] dst_max_llen;
    logic       src_reduce_len;
    logic       dst_reduce_len;
  } beo_opt_t;
  typedef struct packed {
    logic [2:0] src_protocol;
    logic [2:0] dst_protocol;
    logic [3:0] axi_id;
    axi_opt_t   src;
    axi_opt_t   dst;
    beo_opt_t   beo;
    logic       last;
  } burst_opt_t;
  typedef struct packed {
    logic [63:0] length;
    logic [63:0] src_addr;
    logic [63:0] dst_addr;
    burst_opt_t  opt;
  } idma_burst_req_t;
endpackage

// File: rtl/idma_desc_queue.sv
// idma_desc_queue: synchronous FIFO holding transfer descriptors
module idma_desc_queue #(
  parameter int unsigned DEPTH = 4,
  parameter type dtype = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  dtype                     data_i,
  input  logic                     pop_i,
  output dtype                     data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  dtype mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level_q;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = mem[rptr];
  assign full_o = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  always_ff @(posedge clk_i)
    if (do_push) mem[wptr] <= data_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/idma_reg_queue_frontend.sv
// idma_reg_queue_frontend: register frontend queueing iDMA transfers with in-flight limit and completion IRQ
module idma_reg_queue_frontend
  import idma_reg_queue_pkg::*;
#(
  parameter int unsigned RegWidth = 64,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter type burst_req_t = idma_burst_req_t
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                reg_valid_i,
  input  logic                reg_write_i,
  input  logic [2:0]          reg_addr_i,
  input  logic [RegWidth-1:0] reg_wdata_i,
  output logic                reg_rvalid_o,
  output logic [RegWidth-1:0] reg_rdata_o,
  output burst_req_t          burst_req_o,
  output logic                valid_o,
  input  logic                ready_i,
  input  logic                backend_idle_i,
  input  logic                trans_complete_i,
  output logic                irq_o
);
  localparam int unsigned LW = $clog2(QueueDepth) + 1;
  localparam int unsigned OW = $clog2(MaxOutstanding + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MaxOutstanding);
  typedef struct packed {
    logic [1:0]           conf;
    logic [AddrWidth-1:0] num_bytes;
    logic [AddrWidth-1:0] dst_addr;
    logic [AddrWidth-1:0] src_addr;
  } desc_t;
  logic [AddrWidth-1:0] src_q, dst_q, num_q;
  logic [CONF_W-1:0] conf_q;
  logic [RegWidth-1:0] next_id, done_id, rdata_d, rdata_q;
  logic [OW-1:0] out_q;
  logic irq_q, rvalid_q, rd, wr, enq, hs, busy, full, empty;
  logic [LW-1:0] level;
  desc_t snap, head;
  // 0 is reserved as the "rejected" answer, so IDs skip it on wrap
  function automatic logic [RegWidth-1:0] inc_id(input logic [RegWidth-1:0] v);
    return &v ? RegWidth'(1) : v + RegWidth'(1);
  endfunction
  assign rd = reg_valid_i && !reg_write_i;
  assign wr = reg_valid_i && reg_write_i;
  assign enq = rd && reg_addr_i == REG_NEXT_ID && num_q != '0 && !full;
  assign valid_o = !empty && out_q < MAX_OUT;
  assign hs = valid_o && ready_i;
  assign busy = !empty || out_q != '0 || !backend_idle_i;
  assign irq_o = irq_q;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o = rdata_q;
  assign snap = '{conf: conf_q[1:0], num_bytes: num_q, dst_addr: dst_q, src_addr: src_q};
  idma_desc_queue #(.DEPTH(QueueDepth), .dtype(desc_t)) i_queue (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (enq),
    .data_i (snap),
    .pop_i  (hs),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );
  always_comb begin
    rdata_d = '0;
    case (reg_addr_i)
      REG_SRC_ADDR:  rdata_d = RegWidth'(src_q);
      REG_DST_ADDR:  rdata_d = RegWidth'(dst_q);
      REG_NUM_BYTES: rdata_d = RegWidth'(num_q);
      REG_CONF:      rdata_d = RegWidth'(conf_q);
      REG_STATUS: begin
        rdata_d[STATUS_BUSY] = busy;
        rdata_d[STATUS_FULL] = full;
        rdata_d[STATUS_LEVEL +: LW] = level;
      end
      REG_NEXT_ID:   rdata_d = enq ? next_id : '0;
      REG_DONE_ID:   rdata_d = done_id;
      default:       rdata_d[IRQ_PENDING] = irq_q;
    endcase
  end
  always_comb begin
    burst_req_o = '0;
    if (!empty) begin
      burst_req_o.length = head.num_bytes;
      burst_req_o.src_addr = head.src_addr;
      burst_req_o.dst_addr = head.dst_addr;
      burst_req_o.opt.src.burst = BURST_INCR;
      burst_req_o.opt.dst.burst = BURST_INCR;
      burst_req_o.opt.beo.decouple_rw = head.conf[CONF_DECOUPLE];
      burst_req_o.opt.beo.src_reduce_len = head.conf[CONF_DEBURST];
      burst_req_o.opt.beo.dst_reduce_len = head.conf[CONF_DEBURST];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q <= '0;
      dst_q <= '0;
      num_q <= '0;
      conf_q <= '0;
      next_id <= RegWidth'(1);
      done_id <= '0;
      out_q <= '0;
      irq_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rvalid_q <= reg_valid_i;
      rdata_q <= rd ? rdata_d : '0;
      if (wr && reg_addr_i == REG_SRC_ADDR) src_q <= reg_wdata_i[AddrWidth-1:0];
      if (wr && reg_addr_i == REG_DST_ADDR) dst_q <= reg_wdata_i[AddrWidth-1:0];
      if (wr && reg_addr_i == REG_NUM_BYTES) num_q <= reg_wdata_i[AddrWidth-1:0];
      if (wr && reg_addr_i == REG_CONF) conf_q <= reg_wdata_i[CONF_W-1:0];
      if (enq) next_id <= inc_id(next_id);
      if (trans_complete_i) done_id <= inc_id(done_id);
      if (hs && !trans_complete_i) out_q <= out_q + 1'b1;
      else if (!hs && trans_complete_i && out_q != '0) out_q <= out_q - 1'b1;
      if (trans_complete_i && conf_q[CONF_IRQ_EN]) irq_q <= 1'b1;
      else if (wr && reg_addr_i == REG_IRQ && reg_wdata_i[IRQ_PENDING]) irq_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_idma_reg_queue_frontend.sv
// tb_idma_reg_queue_frontend: directed and randomized checks against a queue-based reference model
module tb_idma_reg_queue_frontend;
  import idma_reg_queue_pkg::*;
  localparam int QD = 4;
  localparam int MO = 2;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic reg_valid = 1'b0, reg_write = 1'b0;
  logic [2:0] reg_addr = '0;
  logic [63:0] reg_wdata = '0;
  logic reg_rvalid, valid, irq;
  logic [63:0] reg_rdata;
  idma_burst_req_t burst_req;
  logic ready = 1'b0, idle = 1'b1, tc = 1'b0;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [63:0] s, d, n; logic [2:0] c; } desc_t;
  desc_t mq[$];
  logic [63:0] m_src, m_dst, m_nb, m_nid, m_did, m_rd;
  logic [2:0] m_conf;
  int m_out;
  bit m_pend, m_rv;
  always #5 clk_i = ~clk_i;
  idma_reg_queue_frontend #(.RegWidth(64), .AddrWidth(64), .QueueDepth(QD), .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .reg_valid_i(reg_valid), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
    .reg_wdata_i(reg_wdata), .reg_rvalid_o(reg_rvalid), .reg_rdata_o(reg_rdata), .burst_req_o(burst_req),
    .valid_o(valid), .ready_i(ready), .backend_idle_i(idle), .trans_complete_i(tc), .irq_o(irq)
  );
  function automatic logic [63:0] nxt(input logic [63:0] v);
    return (v == '1) ? 64'd1 : v + 64'd1;
  endfunction
  function automatic idma_burst_req_t exp_burst();
    idma_burst_req_t b = '0;
    b.length = mq[0].n;
    b.src_addr = mq[0].s;
    b.dst_addr = mq[0].d;
    b.opt.src.burst = BURST_INCR;
    b.opt.dst.burst = BURST_INCR;
    b.opt.beo.decouple_rw = mq[0].c[0];
    b.opt.beo.src_reduce_len = mq[0].c[1];
    b.opt.beo.dst_reduce_len = mq[0].c[1];
    return b;
  endfunction
  function automatic void model_reset();
    mq.delete();
    {m_src, m_dst, m_nb, m_did, m_rd} = '0;
    m_nid = 64'd1;
    m_conf = '0;
    m_out = 0;
    m_pend = 0;
    m_rv = 0;
  endfunction
  function automatic void model_step();
    int sz = mq.size();
    bit rd = reg_valid && !reg_write;
    bit wr = reg_valid && reg_write;
    bit hs = sz != 0 && m_out < MO && ready;
    bit enq = rd && reg_addr == 3'd5 && m_nb != 0 && sz < QD;
    logic [63:0] rdv = '0;
    if (rd)
      case (reg_addr)
        3'd0: rdv = m_src;
        3'd1: rdv = m_dst;
        3'd2: rdv = m_nb;
        3'd3: rdv = 64'(m_conf);
        3'd4: rdv = 64'(sz * 4 + (sz == QD ? 2 : 0) + ((sz != 0 || m_out != 0 || !idle) ? 1 : 0));
        3'd5: rdv = enq ? m_nid : '0;
        3'd6: rdv = m_did;
        default: rdv = 64'(m_pend);
      endcase
    if (tc && m_conf[2]) m_pend = 1;
    else if (wr && reg_addr == 3'd7 && reg_wdata[0]) m_pend = 0;
    if (hs) void'(mq.pop_front());
    if (enq) begin
      mq.push_back('{s: m_src, d: m_dst, n: m_nb, c: m_conf});
      m_nid = nxt(m_nid);
    end
    if (wr && reg_addr == 3'd0) m_src = reg_wdata;
    if (wr && reg_addr == 3'd1) m_dst = reg_wdata;
    if (wr && reg_addr == 3'd2) m_nb = reg_wdata;
    if (wr && reg_addr == 3'd3) m_conf = reg_wdata[2:0];
    if (tc) m_did = nxt(m_did);
    if (hs && !tc) m_out++;
    else if (!hs && tc && m_out > 0) m_out--;
    m_rv = reg_valid;
    m_rd = rdv;
  endfunction
  task automatic tick();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else model_step();
    @(negedge clk_i);
    reg_valid = 0;
    reg_write = 0;
    reg_addr = '0;
    reg_wdata = '0;
    tc = 0;
  endtask
  task automatic wr_reg(input logic [2:0] a, input logic [63:0] d);
    reg_valid = 1;
    reg_write = 1;
    reg_addr = a;
    reg_wdata = d;
    tick();
  endtask
  task automatic rd_reg(input logic [2:0] a);
    reg_valid = 1;
    reg_write = 0;
    reg_addr = a;
    tick();
  endtask
  task automatic do_reset();
    rst_i = 1;
    ready = 0;
    idle = 1;
    tick();
    rst_i = 0;
  endtask
  task automatic test_reset();
    do_reset();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_chk++; if (reg_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", reg_rvalid); end
    n_chk++; if (burst_req !== '0) begin n_fail++; $display("FAIL reset_burst: got %h want 0", burst_req); end
    rd_reg(3'd4);
    n_chk++; if (reg_rvalid !== 1'b1 || reg_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_status: got %b/%h want 1/0", reg_rvalid, reg_rdata); end
  endtask
  task automatic test_single();
    do_reset();
    wr_reg(3'd0, 64'h1000);
    wr_reg(3'd1, 64'h2000);
    wr_reg(3'd2, 64'h40);
    rd_reg(3'd5);
    n_chk++; if (reg_rdata !== 64'd1) begin n_fail++; $display("FAIL single_id: got %h want 1", reg_rdata); end
    n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", valid); end
    n_chk++;
    if (burst_req.length !== 64'h40 || burst_req.src_addr !== 64'h1000 || burst_req.dst_addr !== 64'h2000 || burst_req !== exp_burst()) begin
      n_fail++; $display("FAIL single_burst: got %h want %h", burst_req, exp_burst());
    end
    ready = 1;
    tick();
    ready = 0;
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %b want 0", valid); end
    tc = 1;
    tick();
    rd_reg(3'd6);
    n_chk++; if (reg_rdata !== 64'd1) begin n_fail++; $display("FAIL single_done_id: got %h want 1", reg_rdata); end
  endtask
  task automatic test_reject();
    do_reset();
    rd_reg(3'd5);
    n_chk++; if (reg_rvalid !== 1'b1 || reg_rdata !== 64'd0) begin n_fail++; $display("FAIL reject_id: got %b/%h want 1/0", reg_rvalid, reg_rdata); end
    tick();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reject_valid: got %b want 0", valid); end
    wr_reg(3'd2, 64'h10);
    rd_reg(3'd5);
    n_chk++; if (reg_rdata !== 64'd1) begin n_fail++; $display("FAIL reject_next_id: got %h want 1", reg_rdata); end
  endtask
  task automatic test_full();
    logic [63:0] want [5] = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd0};
    do_reset();
    wr_reg(3'd2, 64'h40);
    for (int i = 0; i < 5; i++) begin
      rd_reg(3'd5);
      n_chk++; if (reg_rdata !== want[i]) begin n_fail++; $display("FAIL full_id%0d: got %h want %h", i, reg_rdata, want[i]); end
    end
    rd_reg(3'd4);
    n_chk++; if (reg_rdata !== 64'h13) begin n_fail++; $display("FAIL full_status: got %h want 13", reg_rdata); end
  endtask
  task automatic test_outstanding();
    int hs_cnt = 0;
    ready = 1;
    repeat (6) begin
      if (valid && ready) hs_cnt++;
      tick();
    end
    n_chk++; if (hs_cnt != 2) begin n_fail++; $display("FAIL outst_limit: got %0d want 2", hs_cnt); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL outst_valid: got %b want 0", valid); end
    tc = 1;
    if (valid && ready) hs_cnt++;
    tick();
    repeat (4) begin
      if (valid && ready) hs_cnt++;
      tick();
    end
    n_chk++; if (hs_cnt != 3) begin n_fail++; $display("FAIL outst_refill: got %0d want 3", hs_cnt); end
    ready = 0;
    rd_reg(3'd4);
    n_chk++; if (reg_rdata !== 64'h5 || reg_rdata !== m_rd) begin n_fail++; $display("FAIL outst_status: got %h want 5", reg_rdata); end
  endtask
  task automatic test_irq();
    do_reset();
    wr_reg(3'd3, 64'h4);
    tc = 1;
    tick();
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
    tc = 1;
    wr_reg(3'd7, 64'h1);
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    wr_reg(3'd7, 64'h1);
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
    wr_reg(3'd3, 64'h0);
    tc = 1;
    tick();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b want 0", irq); end
    rd_reg(3'd6);
    n_chk++; if (reg_rdata !== 64'd3) begin n_fail++; $display("FAIL irq_done_id: got %h want 3", reg_rdata); end
    wr_reg(3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_reg(3'd3);
    n_chk++; if (reg_rdata !== 64'h7) begin n_fail++; $display("FAIL conf_mask: got %h want 7", reg_rdata); end
  endtask
  task automatic test_wrap_and_reset();
    do_reset();
    wr_reg(3'd2, 64'h80);
    force dut.next_id = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.next_id;
    m_nid = '1;
    rd_reg(3'd5);
    n_chk++; if (reg_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL wrap_max: got %h want all-ones", reg_rdata); end
    rd_reg(3'd5);
    n_chk++; if (reg_rdata !== 64'd1) begin n_fail++; $display("FAIL wrap_one: got %h want 1", reg_rdata); end
    n_chk++; if (valid !== 1'b1 || burst_req !== exp_burst()) begin n_fail++; $display("FAIL wrap_burst: got %b/%h want 1/%h", valid, burst_req, exp_burst()); end
    reg_valid = 1;
    reg_addr = 3'd4;
    rst_i = 1;
    tick();
    rst_i = 0;
    n_chk++; if (valid !== 1'b0 || reg_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got %b/%b want 0/0", valid, reg_rvalid); end
    rd_reg(3'd4);
    n_chk++; if (reg_rdata !== 64'd0) begin n_fail++; $display("FAIL midrst_status: got %h want 0", reg_rdata); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      n_chk++; if (valid !== (mq.size() != 0 && m_out < MO)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, valid, mq.size() != 0 && m_out < MO); end
      if (mq.size() != 0 && m_out < MO) begin
        n_chk++; if (burst_req !== exp_burst()) begin n_fail++; $display("FAIL rnd_burst@%0d: got %h want %h", i, burst_req, exp_burst()); end
      end
      n_chk++; if (irq !== m_pend) begin n_fail++; $display("FAIL rnd_irq@%0d: got %b want %b", i, irq, m_pend); end
      n_chk++; if (reg_rvalid !== m_rv || reg_rdata !== m_rd) begin n_fail++; $display("FAIL rnd_resp@%0d: got %b/%h want %b/%h", i, reg_rvalid, reg_rdata, m_rv, m_rd); end
      reg_valid = $urandom_range(0, 1);
      reg_write = $urandom_range(0, 2) == 0;
      reg_addr = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      reg_wdata = {$urandom, $urandom};
      if (reg_addr == 3'd2 && $urandom_range(0, 3) == 0) reg_wdata = '0;
      ready = $urandom_range(0, 1);
      idle = $urandom_range(0, 3) != 0;
      tc = $urandom_range(0, 3) == 0;
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_reject();
    test_full();
    test_outstanding();
    test_irq();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
